// File: rtl/gencon_param.sv
// rtl/gencon_param.sv - parametrised signed keypad calculator controller with saturating add/sub/mul
module gencon_param #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [3:0]       keypad_input,
    input  logic             read_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    output logic             complete,
    output logic             overflow,
    output logic [WIDTH-1:0] display_output,
    output logic [2:0]       current_state
);

    localparam int ACCW = WIDTH + 4;
    localparam int MAGW = 2 * WIDTH + 4;
    localparam int CNTW = $clog2(MAX_DIGITS + 1);
    localparam int MCW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] S_ENTER_A = 3'd0;
    localparam logic [2:0] S_ENTER_B = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [WIDTH-1:0] VAL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] VAL_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [MAGW-1:0]  NEG_LIM = MAGW'(VAL_MIN);
    localparam logic [MAGW-1:0]  POS_LIM = MAGW'(VAL_MAX);

    // Turns an unsigned magnitude plus sign into a clamped signed value; returns {saturated, value}.
    function automatic logic [WIDTH:0] clamp_mag(input logic [MAGW-1:0] mag, input logic neg);
        logic [WIDTH-1:0] low;
        logic [WIDTH-1:0] low_neg;
        low     = mag[WIDTH-1:0];
        low_neg = ~low + 1'b1;
        if (neg) begin
            if (mag > NEG_LIM) clamp_mag = {1'b1, VAL_MIN};
            else               clamp_mag = {1'b0, low_neg};
        end else begin
            if (mag > POS_LIM) clamp_mag = {1'b1, VAL_MAX};
            else               clamp_mag = {1'b0, low};
        end
    endfunction

    logic [2:0]         state;
    logic [ACCW-1:0]    acc;
    logic [CNTW-1:0]    digit_cnt;
    logic               sign;
    logic [1:0]         op;
    logic [WIDTH-1:0]   a_val;
    logic [WIDTH-1:0]   b_val;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   hold_disp;
    logic               ovf_q;
    logic               read_prev;
    logic [2:0]         op_prev;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [MCW-1:0]     mul_cnt;
    logic               mul_neg;

    logic               read_rise;
    logic               op_edge;
    logic               do_clear;
    logic               do_neg;
    logic               do_arith;
    logic [1:0]         op_code;
    logic               digit_ok;
    logic               digit_take;
    logic [ACCW+3:0]    acc_wide;
    logic [ACCW-1:0]    acc_dig;
    logic [WIDTH-1:0]   acc_low;
    logic [WIDTH-1:0]   live_val;
    logic [WIDTH:0]     fin;
    logic [WIDTH-1:0]   fin_val;
    logic               fin_ovf;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     sum;
    logic               sum_ovf;
    logic [WIDTH-1:0]   sum_val;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     prod_fin;
    logic               mul_last;

    assign read_rise  = read_input & ~read_prev;
    assign op_edge    = (operator_input != 3'b000) && (op_prev == 3'b000);
    assign do_clear   = op_edge && (operator_input == 3'b111);
    assign do_neg     = op_edge && (operator_input == 3'b001);
    assign do_arith   = op_edge && ((operator_input == 3'b010) || (operator_input == 3'b011) ||
                                    (operator_input == 3'b100));
    assign op_code    = (operator_input == 3'b011) ? OP_SUB :
                        (operator_input == 3'b100) ? OP_MUL : OP_ADD;
    assign digit_ok   = read_rise && (keypad_input <= 4'd9);
    assign digit_take = digit_ok && (digit_cnt < CNTW'(MAX_DIGITS));

    // acc*10 + digit, computed wide enough that the saturation test sees the true value.
    assign acc_wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + (ACCW+4)'(keypad_input);
    assign acc_dig  = (acc_wide[ACCW+3:ACCW] != 4'b0000) ? {ACCW{1'b1}} : acc_wide[ACCW-1:0];

    assign acc_low  = acc[WIDTH-1:0];
    assign live_val = sign ? (~acc_low + 1'b1) : acc_low;

    assign fin     = clamp_mag(MAGW'(acc), sign);
    assign fin_val = fin[WIDTH-1:0];
    assign fin_ovf = fin[WIDTH];

    assign a_mag = a_val[WIDTH-1] ? (~a_val + 1'b1) : a_val;
    assign b_mag = fin_val[WIDTH-1] ? (~fin_val + 1'b1) : fin_val;

    assign a_ext   = {a_val[WIDTH-1], a_val};
    assign b_ext   = {b_val[WIDTH-1], b_val};
    assign sum     = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    assign sum_val = !sum_ovf ? sum[WIDTH-1:0] : (sum[WIDTH] ? VAL_MIN : VAL_MAX);

    assign prod_next = prod + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});
    assign prod_fin  = clamp_mag(MAGW'(prod_next), mul_neg);
    assign mul_last  = (mul_cnt == MCW'(WIDTH - 1));

    assign complete       = (state == S_DONE);
    assign overflow       = ovf_q;
    assign current_state  = state;
    assign display_output = (state == S_DONE)    ? result :
                            (state == S_COMPUTE) ? hold_disp : live_val;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= S_ENTER_A;
            acc       <= '0;
            digit_cnt <= '0;
            sign      <= 1'b0;
            op        <= OP_ADD;
            a_val     <= '0;
            b_val     <= '0;
            result    <= '0;
            hold_disp <= '0;
            ovf_q     <= 1'b0;
            read_prev <= 1'b0;
            op_prev   <= 3'b000;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            mul_cnt   <= '0;
            mul_neg   <= 1'b0;
        end else begin
            read_prev <= read_input;
            op_prev   <= operator_input;
            if (state != S_COMPUTE) hold_disp <= display_output;

            if (do_clear) begin
                state     <= S_ENTER_A;
                acc       <= '0;
                digit_cnt <= '0;
                sign      <= 1'b0;
                op        <= OP_ADD;
                a_val     <= '0;
                b_val     <= '0;
                result    <= '0;
                hold_disp <= '0;
                ovf_q     <= 1'b0;
                mcand     <= '0;
                mplier    <= '0;
                prod      <= '0;
                mul_cnt   <= '0;
                mul_neg   <= 1'b0;
            end else begin
                case (state)
                    S_ENTER_A: begin
                        if (do_arith) begin
                            a_val     <= fin_val;
                            ovf_q     <= ovf_q | fin_ovf;
                            op        <= op_code;
                            acc       <= '0;
                            sign      <= 1'b0;
                            digit_cnt <= '0;
                            state     <= S_ENTER_B;
                        end else if (do_neg) begin
                            sign <= ~sign;
                        end else if (digit_take) begin
                            acc       <= acc_dig;
                            digit_cnt <= digit_cnt + 1'b1;
                        end
                    end
                    S_ENTER_B: begin
                        if (equal_input) begin
                            b_val   <= fin_val;
                            ovf_q   <= ovf_q | fin_ovf;
                            mcand   <= {{WIDTH{1'b0}}, a_mag};
                            mplier  <= b_mag;
                            prod    <= '0;
                            mul_cnt <= '0;
                            mul_neg <= a_val[WIDTH-1] ^ fin_val[WIDTH-1];
                            state   <= S_COMPUTE;
                        end else if (do_arith) begin
                            op <= op_code;
                        end else if (do_neg) begin
                            sign <= ~sign;
                        end else if (digit_take) begin
                            acc       <= acc_dig;
                            digit_cnt <= digit_cnt + 1'b1;
                        end
                    end
                    S_COMPUTE: begin
                        if (op != OP_MUL) begin
                            result <= sum_val;
                            ovf_q  <= ovf_q | sum_ovf;
                            state  <= S_DONE;
                        end else begin
                            prod    <= prod_next;
                            mcand   <= mcand << 1;
                            mplier  <= mplier >> 1;
                            mul_cnt <= mul_cnt + 1'b1;
                            if (mul_last) begin
                                result <= prod_fin[WIDTH-1:0];
                                ovf_q  <= ovf_q | prod_fin[WIDTH];
                                state  <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        if (do_arith) begin
                            a_val     <= result;
                            op        <= op_code;
                            ovf_q     <= 1'b0;
                            acc       <= '0;
                            sign      <= 1'b0;
                            digit_cnt <= '0;
                            state     <= S_ENTER_B;
                        end else if (do_neg) begin
                            // -min has no positive counterpart, so it clamps to max.
                            if (result == VAL_MIN) begin
                                result <= VAL_MAX;
                                ovf_q  <= 1'b1;
                            end else begin
                                result <= ~result + 1'b1;
                            end
                        end else if (digit_ok) begin
                            acc       <= {{(ACCW-4){1'b0}}, keypad_input};
                            digit_cnt <= CNTW'(1);
                            sign      <= 1'b0;
                            ovf_q     <= 1'b0;
                            state     <= S_ENTER_A;
                        end
                    end
                    default: state <= S_ENTER_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gencon_param.sv
// tb/tb_gencon_param.sv - self-checking bench for gencon_param at WIDTH=16 and WIDTH=8
module tb_gencon_param;

    logic        clk = 1'b0;
    logic        RST;
    logic [3:0]  keypad_input;
    logic        read_input;
    logic [2:0]  operator_input;
    logic        equal_input;

    logic        c16, o16, c8, o8;
    logic [15:0] d16;
    logic [7:0]  d8;
    logic [2:0]  s16, s8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gencon_param #(.WIDTH(16), .MAX_DIGITS(5)) dut16 (
        .clk(clk), .RST(RST), .keypad_input(keypad_input), .read_input(read_input),
        .operator_input(operator_input), .equal_input(equal_input),
        .complete(c16), .overflow(o16), .display_output(d16), .current_state(s16)
    );

    gencon_param #(.WIDTH(8), .MAX_DIGITS(3)) dut8 (
        .clk(clk), .RST(RST), .keypad_input(keypad_input), .read_input(read_input),
        .operator_input(operator_input), .equal_input(equal_input),
        .complete(c8), .overflow(o8), .display_output(d8), .current_state(s8)
    );

    typedef struct {
        int          a;
        bit          an;
        logic [2:0]  op;
        int          b;
        bit          bn;
        logic [15:0] exp_d;
        logic        exp_o;
        int          exp_lat;
    } vec_t;

    vec_t vt [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_digit(input logic [3:0] d);
        keypad_input = d;
        read_input   = 1'b1;
        tick(1);
        read_input   = 1'b0;
        tick(1);
    endtask

    task automatic press_op(input logic [2:0] o);
        operator_input = o;
        tick(1);
        operator_input = 3'b000;
        tick(1);
    endtask

    task automatic enter_num(input int mag, input bit neg, input bit neg_first);
        int d[$];
        int m;
        m = mag;
        if (neg && neg_first) press_op(3'b001);
        while (m > 0) begin
            d.push_front(m % 10);
            m = m / 10;
        end
        foreach (d[i]) press_digit(4'(d[i]));
        if (neg && !neg_first) press_op(3'b001);
    endtask

    task automatic wait_done(input bit w8, output int lat);
        lat = 0;
        while (((w8 ? c8 : c16) !== 1'b1) && (lat < 64)) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic do_equal(input bit w8, output int lat);
        equal_input = 1'b1;
        tick(1);
        equal_input = 1'b0;
        wait_done(w8, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  saw_complete;

        vt[0]  = '{25,    1'b1, 3'b010, 15,   1'b1, 16'hFFD8, 1'b0, 1};
        vt[1]  = '{128,   1'b0, 3'b100, 256,  1'b0, 16'h7FFF, 1'b1, 16};
        vt[2]  = '{12,    1'b1, 3'b100, 3000, 1'b0, 16'h8000, 1'b1, 16};
        vt[3]  = '{32768, 1'b1, 3'b100, 1,    1'b0, 16'h8000, 1'b0, 16};
        vt[4]  = '{99999, 1'b0, 3'b010, 0,    1'b0, 16'h7FFF, 1'b1, 1};
        vt[5]  = '{300,   1'b0, 3'b011, 1000, 1'b1, 16'h0514, 1'b0, 1};
        vt[6]  = '{20000, 1'b0, 3'b010, 20000, 1'b0, 16'h7FFF, 1'b1, 1};
        vt[7]  = '{20000, 1'b1, 3'b011, 20000, 1'b0, 16'h8000, 1'b1, 1};
        vt[8]  = '{181,   1'b0, 3'b100, 181,  1'b0, 16'h7FF9, 1'b0, 16};
        vt[9]  = '{7,     1'b1, 3'b100, 9,    1'b1, 16'h003F, 1'b0, 16};
        vt[10] = '{32768, 1'b0, 3'b010, 0,    1'b0, 16'h7FFF, 1'b1, 1};

        RST            = 1'b1;
        keypad_input   = 4'd0;
        read_input     = 1'b0;
        operator_input = 3'b000;
        equal_input    = 1'b0;
        tick(2);
        RST = 1'b0;
        tick(1);
        check("reset_state", 32'(s16), 32'd0);
        check("reset_complete", 32'(c16), 32'd0);
        check("reset_overflow", 32'(o16), 32'd0);
        check("reset_display", 32'(d16), 32'd0);
        check("reset_state_w8", 32'(s8), 32'd0);

        for (int i = 0; i < 11; i++) begin
            press_op(3'b111);
            enter_num(vt[i].a, vt[i].an, 1'b1);
            press_op(vt[i].op);
            enter_num(vt[i].b, vt[i].bn, 1'b0);
            do_equal(1'b0, lat);
            check($sformatf("vec%0d_display", i), 32'(d16), 32'(vt[i].exp_d));
            check($sformatf("vec%0d_overflow", i), 32'(o16), 32'(vt[i].exp_o));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
        end

        // -32768 * 1, then negate in DONE clamps to max
        press_op(3'b111);
        enter_num(32768, 1'b1, 1'b1);
        press_op(3'b100);
        enter_num(1, 1'b0, 1'b0);
        do_equal(1'b0, lat);
        press_op(3'b001);
        check("negmin_display", 32'(d16), 32'h7FFF);
        check("negmin_overflow", 32'(o16), 32'd1);
        check("negmin_state", 32'(s16), 32'd6);

        // chain: 5 - 3 = 2, + 4 = 6, negate, then new digit
        press_op(3'b111);
        enter_num(5, 1'b0, 1'b1);
        press_op(3'b011);
        enter_num(3, 1'b0, 1'b0);
        do_equal(1'b0, lat);
        check("chain_first", 32'(d16), 32'd2);
        press_op(3'b010);
        check("chain_state_b", 32'(s16), 32'd3);
        check("chain_complete_low", 32'(c16), 32'd0);
        press_digit(4'd4);
        do_equal(1'b0, lat);
        check("chain_second", 32'(d16), 32'd6);
        press_op(3'b001);
        check("done_negate", 32'(d16), 32'hFFFA);
        check("done_negate_ovf", 32'(o16), 32'd0);
        press_digit(4'd7);
        check("restart_state", 32'(s16), 32'd0);
        check("restart_display", 32'(d16), 32'd7);
        check("restart_overflow", 32'(o16), 32'd0);

        // equal and digit in the same cycle: the digit is discarded
        press_op(3'b111);
        enter_num(9, 1'b0, 1'b1);
        press_op(3'b010);
        press_digit(4'd1);
        keypad_input = 4'd5;
        read_input   = 1'b1;
        equal_input  = 1'b1;
        tick(1);
        read_input   = 1'b0;
        equal_input  = 1'b0;
        wait_done(1'b0, lat);
        check("prio_equal_digit", 32'(d16), 32'd10);

        // clear in the 8th COMPUTE cycle of a multiply
        press_op(3'b111);
        enter_num(128, 1'b0, 1'b1);
        press_op(3'b100);
        enter_num(256, 1'b0, 1'b0);
        equal_input = 1'b1;
        tick(1);
        equal_input = 1'b0;
        check("compute_state", 32'(s16), 32'd5);
        check("compute_hold_display", 32'(d16), 32'd256);
        saw_complete = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            if (c16 === 1'b1) saw_complete = 1'b1;
        end
        check("compute_8th_state", 32'(s16), 32'd5);
        operator_input = 3'b111;
        tick(1);
        operator_input = 3'b000;
        check("clear_state", 32'(s16), 32'd0);
        check("clear_display", 32'(d16), 32'd0);
        for (int k = 0; k < 20; k++) begin
            if (c16 === 1'b1) saw_complete = 1'b1;
            tick(1);
        end
        check("clear_no_complete", 32'(saw_complete), 32'd0);

        // asynchronous reset mid-entry
        press_digit(4'd4);
        press_digit(4'd2);
        check("pre_rst_display", 32'(d16), 32'd42);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_state", 32'(s16), 32'd0);
        check("async_rst_display", 32'(d16), 32'd0);
        #1;
        RST = 1'b0;
        tick(1);

        // WIDTH=8: 100 + 100 saturates
        press_op(3'b111);
        enter_num(100, 1'b0, 1'b1);
        press_op(3'b010);
        enter_num(100, 1'b0, 1'b0);
        do_equal(1'b1, lat);
        check("w8_sat_display", 32'(d8), 32'h7F);
        check("w8_sat_overflow", 32'(o8), 32'd1);
        check("w8_sat_latency", 32'(lat), 32'd1);

        // 4th digit ignored at MAX_DIGITS=3, accepted at 5
        press_op(3'b111);
        enter_num(1234, 1'b0, 1'b1);
        check("w8_max_digits", 32'(d8), 32'd123);
        check("w16_four_digits", 32'(d16), 32'd1234);

        // held operator and held negate each count once
        operator_input = 3'b010;
        tick(5);
        operator_input = 3'b000;
        tick(1);
        check("w8_held_op_state", 32'(s8), 32'd3);
        operator_input = 3'b001;
        tick(4);
        operator_input = 3'b000;
        tick(1);
        press_digit(4'd7);
        check("w8_neg_entry", 32'(d8), 32'hF9);
        do_equal(1'b1, lat);
        check("w8_held_result", 32'(d8), 32'd116);
        check("w8_held_overflow", 32'(o8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
